// File: rtl/cmp_result_tally.sv
// Windowed tally of one-hot comparator results (g/e/l).
// Each report gives per-class counts, the illegal-pattern count and the longest run.
module cmp_result_tally #(
  parameter int WINDOW = 16,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          g,
  input  logic          e,
  input  logic          l,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt_g,
  output logic [CW-1:0] cnt_e,
  output logic [CW-1:0] cnt_l,
  output logic [CW-1:0] cnt_bad,
  output logic [CW-1:0] max_run
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic {ACC = 1'b0, REPORT = 1'b1} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_G, RES_E, RES_L} res_t;

  state_t        state_reg, state_next;
  res_t          last_res_reg, last_res_next;
  res_t          res;
  logic          legal;
  logic [CW-1:0] cnt_g_reg, cnt_g_next;
  logic [CW-1:0] cnt_e_reg, cnt_e_next;
  logic [CW-1:0] cnt_l_reg, cnt_l_next;
  logic [CW-1:0] cnt_bad_reg, cnt_bad_next;
  logic [CW-1:0] cur_run_reg, cur_run_next;
  logic [CW-1:0] max_run_reg, max_run_next;
  logic [WW-1:0] win_reg, win_next;

  always_comb begin
    res   = RES_NONE;
    legal = 1'b0;
    case ({g, e, l})
      3'b100:  begin res = RES_G; legal = 1'b1; end
      3'b010:  begin res = RES_E; legal = 1'b1; end
      3'b001:  begin res = RES_L; legal = 1'b1; end
      default: begin res = RES_NONE; legal = 1'b0; end
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    last_res_next = last_res_reg;
    cnt_g_next    = cnt_g_reg;
    cnt_e_next    = cnt_e_reg;
    cnt_l_next    = cnt_l_reg;
    cnt_bad_next  = cnt_bad_reg;
    cur_run_next  = cur_run_reg;
    max_run_next  = max_run_reg;
    win_next      = win_reg;
    case (state_reg)
      ACC: begin
        if (in_valid) begin
          win_next = win_reg + 1'b1;
          if (legal) begin
            if (res == RES_G) cnt_g_next = cnt_g_reg + ONE;
            if (res == RES_E) cnt_e_next = cnt_e_reg + ONE;
            if (res == RES_L) cnt_l_next = cnt_l_reg + ONE;
            // last_res is NONE after an illegal sample, so that never extends a run
            cur_run_next  = (res == last_res_reg) ? cur_run_reg + ONE : ONE;
            last_res_next = res;
            if (cur_run_next > max_run_reg) max_run_next = cur_run_next;
          end else begin
            cnt_bad_next  = cnt_bad_reg + ONE;
            cur_run_next  = '0;
            last_res_next = RES_NONE;
          end
          if (win_reg == WIN_LAST) state_next = REPORT;
        end
      end
      REPORT: begin
        // Inputs are ignored here, including on the handshake edge
        if (out_ready) begin
          state_next    = ACC;
          last_res_next = RES_NONE;
          cnt_g_next    = '0;
          cnt_e_next    = '0;
          cnt_l_next    = '0;
          cnt_bad_next  = '0;
          cur_run_next  = '0;
          max_run_next  = '0;
          win_next      = '0;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ACC;
      last_res_reg <= RES_NONE;
      cnt_g_reg    <= '0;
      cnt_e_reg    <= '0;
      cnt_l_reg    <= '0;
      cnt_bad_reg  <= '0;
      cur_run_reg  <= '0;
      max_run_reg  <= '0;
      win_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      last_res_reg <= last_res_next;
      cnt_g_reg    <= cnt_g_next;
      cnt_e_reg    <= cnt_e_next;
      cnt_l_reg    <= cnt_l_next;
      cnt_bad_reg  <= cnt_bad_next;
      cur_run_reg  <= cur_run_next;
      max_run_reg  <= max_run_next;
      win_reg      <= win_next;
    end
  end

  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == REPORT);
  assign cnt_g     = cnt_g_reg;
  assign cnt_e     = cnt_e_reg;
  assign cnt_l     = cnt_l_reg;
  assign cnt_bad   = cnt_bad_reg;
  assign max_run   = max_run_reg;

endmodule

// File: doc/cmp_result_tally.md
Name: cmp_result_tally

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Accepts a stream of comparator results (one-hot g/e/l flags) under a valid/ready handshake.
- Accumulates per-window statistics: counts of greater, equal and less results, count of illegal flag patterns, and the longest run of identical consecutive results.
- After every WINDOW accepted samples, presents a summary on a valid/ready output port and holds it until the consumer takes it.

Parameters:
- WINDOW, 16, samples accepted per report; legal range 2..(2^CW - 1), so the counters never overflow.
- CW, 8, width of every count and run-length output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
- in_valid  input  1  comparator result valid this cycle.
- g  input  1  comparator greater flag.
- e  input  1  comparator equal flag.
- l  input  1  comparator less flag.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  summary valid.
- out_ready  input  1  consumer accepts the summary.
- cnt_g  output  CW  number of legal samples with g=1 in the window.
- cnt_e  output  CW  number of legal samples with e=1 in the window.
- cnt_l  output  CW  number of legal samples with l=1 in the window.
- cnt_bad  output  CW  number of samples whose {g,e,l} was not one-hot.
- max_run  output  CW  longest streak of identical consecutive legal results.

Behaviour:
- Reset (rst_n=0, async): state=ACC; all counters, cur_run, max_run and the sample counter = 0; last_res=NONE; in_ready=1; out_valid=0; all count outputs 0.
- FSM states:
  - ACC: in_ready=1, out_valid=0.
  - REPORT: in_ready=0, out_valid=1.
- Accept: a sample is taken only on a rising edge where state=ACC and in_valid=1. With in_valid=0, nothing changes.
- Legal sample: {g,e,l} is exactly one of 100, 010 or 001.
  - Increment the matching cnt_*.
  - If the result equals last_res: cur_run_next = cur_run+1. Otherwise cur_run_next = 1 and last_res = this result.
  - max_run_next = max(max_run, cur_run_next), which includes the current sample.
- Illegal sample: any of 000, 011, 101, 110, 111.
  - cnt_bad+1; last_res=NONE; cur_run=0; max_run unchanged.
  - Still counts toward the window.
- Window counter: counts accepted samples, width $clog2(WINDOW+1).
- ACC -> REPORT: on the accept edge that brings the window count to WINDOW. out_valid is high in the cycle after the WINDOW-th accept (latency 1).
- Output data:
  - cnt_g/e/l/bad and max_run are driven from the accumulator registers.
  - They are stable throughout REPORT and reflect all WINDOW samples.
  - In ACC they show partial running values and carry no meaning while out_valid=0.
- REPORT with out_ready=0: hold state and all outputs unchanged, for any number of cycles.
- REPORT -> ACC: on the edge where out_valid=1 and out_ready=1.
  - Clear all counters, cur_run, max_run and the window count; last_res=NONE.
  - in_ready=1 next cycle.
  - in_valid is ignored during REPORT, including the handshake cycle: no sample is dropped into or carried into the next window.
- out_ready asserted before out_valid has no effect; the handshake completes in the first REPORT cycle.
- Runs never span windows; the first sample of each window starts a new run.
- Invariant in REPORT: cnt_g + cnt_e + cnt_l + cnt_bad = WINDOW, and max_run <= WINDOW - cnt_bad.
- Reset mid-window or mid-REPORT: immediate asynchronous clear to the reset values above; the partial window is discarded.

Test Plan:
(WINDOW=4, CW=8 for all scenarios.)
- Reset then idle: rst_n low then high, in_valid=0 for 10 cycles -> in_ready=1, out_valid=0, all counts 0.
- Mixed window: samples g,g,e,l back-to-back, out_ready=1 -> out_valid high one cycle after the 4th accept. Summary cnt_g=2, cnt_e=1, cnt_l=1, cnt_bad=0, max_run=2. in_ready=1 the following cycle, counts cleared.
- Illegal breaks run: samples e, 000, e, 111 -> cnt_e=2, cnt_bad=2, max_run=1.
- Backpressure: four l samples, out_ready=0 for 5 cycles, in_valid held 1 with g throughout -> summary held with cnt_l=4, max_run=4, in_ready=0. No sample counted. On out_ready=1 the next window starts empty.
- Gapped input: l, idle 3 cycles, l, idle, l, l -> idle cycles do not break the run; max_run=4, cnt_l=4.
- Reset mid-window: accept g,g, pulse rst_n low asynchronously (not clock-aligned), then send e,e,e,e -> cnt_g=0, cnt_e=4, max_run=4.
